// File: rtl/multicycle_arith_machine.sv
// Multi-cycle MIPS-subset arithmetic machine: fetches over a valid/request
// handshake, executes in one cycle against a 32-entry register file, halts on an illegal op.
module multicycle_arith_machine #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 30,
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_inst,
    output logic                except,
    output logic                halted,
    output logic [ADDR_W+1:0]   pc,
    output logic [CNT_W-1:0]    retired,
    input  logic [4:0]          dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);
    localparam int unsigned PC_W = ADDR_W + 2;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                except_q, except_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [32];
    logic [DATA_W-1:0]   regs_d [32];

    logic [5:0]          opcode, funct;
    logic [4:0]          rs, rt, rd, wr_addr;
    logic [15:0]         imm;
    logic [DATA_W-1:0]   rs_val, rt_val, imm_sext, imm_zext, result;
    logic                legal, wr_en;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = DATA_W'(imm);

    // Decode and ALU; r0 stays zero because writes to it are dropped.
    always_comb begin
        result  = '0;
        legal   = 1'b0;
        wr_addr = rt;
        case (opcode)
            6'h00: begin
                wr_addr = rd;
                legal   = 1'b1;
                case (funct)
                    6'h20:   result = rs_val + rt_val;
                    6'h22:   result = rs_val - rt_val;
                    6'h24:   result = rs_val & rt_val;
                    6'h25:   result = rs_val | rt_val;
                    6'h26:   result = rs_val ^ rt_val;
                    6'h27:   result = ~(rs_val | rt_val);
                    6'h2A:   result = ($signed(rs_val) < $signed(rt_val)) ? DATA_W'(1) : '0;
                    default: legal  = 1'b0;
                endcase
            end
            6'h08: begin legal = 1'b1; result = rs_val + imm_sext; end
            6'h0C: begin legal = 1'b1; result = rs_val & imm_zext; end
            6'h0D: begin legal = 1'b1; result = rs_val | imm_zext; end
            6'h0E: begin legal = 1'b1; result = rs_val ^ imm_zext; end
            6'h0F: begin legal = 1'b1; result = imm_zext << 16; end
            default: legal = 1'b0;
        endcase
    end

    // Next-state logic for the FETCH/EXEC/HALT sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        except_d  = except_q;
        ir_d      = ir_q;
        wr_en     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (legal) begin
                    wr_en     = 1'b1;
                    pc_d      = pc_q + PC_W'(4);
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end else begin
                    except_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != 5'd0)) regs_d[wr_addr] = result;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_W'(RESET_PC);
            retired_q <= '0;
            except_q  <= 1'b0;
            ir_q      <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            except_q  <= except_d;
            ir_q      <= ir_d;
            regs_q    <= regs_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign halted    = (state_q == S_HALT);
    assign imem_addr = pc_q[PC_W-1:2];
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign except    = except_q;
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];

endmodule

// File: tb/tb_multicycle_arith_machine.sv
// Directed bench for multicycle_arith_machine: a 32-bit instance with a
// wait-state memory model and a 20-bit instance checking narrow-datapath wrap.
module tb_multicycle_arith_machine;
    localparam logic [31:0] NOP = 32'h0000_0025;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        imem_req, imem_valid, except, halted;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] pc, retired, dbg_rdata;
    logic [4:0]  dbg_raddr = 5'd0;

    logic        imem_req20, except20, halted20;
    logic [29:0] imem_addr20;
    logic [31:0] imem_inst20, pc20, retired20;
    logic [19:0] dbg_rdata20;
    logic [4:0]  dbg_raddr20 = 5'd0;

    logic [31:0] prog   [16];
    logic [31:0] prog20 [16];
    logic        valid_en = 1'b0;
    logic [3:0]  wait_n = 4'd0;
    logic [3:0]  wcnt = 4'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] rv;

    always #5 clock = ~clock;

    multicycle_arith_machine dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_inst(imem_inst), .except(except), .halted(halted),
        .pc(pc), .retired(retired), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    multicycle_arith_machine #(.DATA_W(20)) dut20 (
        .clock(clock), .reset(reset), .imem_req(imem_req20), .imem_addr(imem_addr20),
        .imem_valid(1'b1), .imem_inst(imem_inst20), .except(except20), .halted(halted20),
        .pc(pc20), .retired(retired20), .dbg_raddr(dbg_raddr20), .dbg_rdata(dbg_rdata20)
    );

    // Instruction memory with a programmable number of wait cycles per fetch.
    assign imem_inst   = prog[imem_addr[3:0]];
    assign imem_inst20 = prog20[imem_addr20[3:0]];
    assign imem_valid  = valid_en && (wcnt >= wait_n);

    always @(posedge clock) begin
        if (reset || !imem_req || imem_valid) wcnt <= 4'd0;
        else                                  wcnt <= wcnt + 4'd1;
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd32(input int a, output logic [63:0] v);
        dbg_raddr = 5'(a);
        #1;
        v = 64'(dbg_rdata);
    endtask

    task automatic rd20(input int a, output logic [63:0] v);
        dbg_raddr20 = 5'(a);
        #1;
        v = 64'(dbg_rdata20);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = NOP;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        clear_prog();
        for (int i = 0; i < 16; i++) prog20[i] = NOP;
        prog20[0] = enc_i(6'h08, 0, 1, 16'hFFFF);
        prog20[1] = enc_r(1, 1, 2, 6'h20);
        prog20[2] = enc_i(6'h0F, 0, 3, 16'h1234);

        // Test 1: back-to-back fetches, two cycles per instruction.
        prog[0] = enc_i(6'h08, 0, 1, 16'h0005);
        prog[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
        prog[2] = enc_r(1, 2, 3, 6'h20);
        valid_en = 1'b1;
        wait_n   = 4'd0;
        @(negedge clock);
        do_reset();
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_except", 64'(except), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", 64'(imem_addr), 64'd0);
        tick(6);
        check("t1_pc", 64'(pc), 64'd12);
        check("t1_retired", 64'(retired), 64'd3);
        check("t1_addr", 64'(imem_addr), 64'd3);
        rd32(3, rv); check("t1_r3", rv, 64'd2);
        rd32(2, rv); check("t1_r2", rv, 64'hFFFF_FFFD);
        rd20(1, rv); check("w20_r1", rv, 64'hF_FFFF);
        rd20(2, rv); check("w20_r2", rv, 64'hF_FFFE);
        rd20(3, rv); check("w20_lui", rv, 64'h4_0000);
        check("w20_pc", 64'(pc20), 64'd12);

        // Test 2: three wait cycles per fetch, address held until accepted.
        clear_prog();
        prog[0] = enc_i(6'h0D, 0, 4, 16'hFFFF);
        wait_n  = 4'd3;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check("t2_wait_addr", 64'(imem_addr), 64'd0);
            check("t2_wait_req", 64'(imem_req), 64'd1);
            check("t2_wait_pc", 64'(pc), 64'd0);
        end
        tick(1);
        check("t2_exec_req", 64'(imem_req), 64'd0);
        tick(1);
        check("t2_pc", 64'(pc), 64'd4);
        check("t2_retired", 64'(retired), 64'd1);
        rd32(4, rv); check("t2_r4", rv, 64'h0000_FFFF);
        tick(5);
        check("t2_pc2", 64'(pc), 64'd8);
        check("t2_retired2", 64'(retired), 64'd2);

        // Test 3: lui/slt/sub and the remaining ALU ops.
        clear_prog();
        prog[0]  = enc_i(6'h0F, 0, 5, 16'h8000);
        prog[1]  = enc_r(5, 0, 6, 6'h2A);
        prog[2]  = enc_r(0, 5, 7, 6'h22);
        prog[3]  = enc_i(6'h0E, 5, 8, 16'h00FF);
        prog[4]  = enc_r(0, 0, 9, 6'h27);
        prog[5]  = enc_i(6'h0C, 9, 10, 16'h1234);
        prog[6]  = enc_r(9, 5, 11, 6'h26);
        prog[7]  = enc_r(0, 5, 12, 6'h2A);
        prog[8]  = enc_r(9, 8, 13, 6'h24);
        prog[9]  = enc_i(6'h08, 5, 14, 16'hFFFF);
        prog[10] = enc_i(6'h08, 0, 15, 16'h8000);
        wait_n   = 4'd0;
        do_reset();
        tick(22);
        rd32(5, rv);  check("t3_lui", rv, 64'h8000_0000);
        rd32(6, rv);  check("t3_slt_neg", rv, 64'd1);
        rd32(7, rv);  check("t3_sub", rv, 64'h8000_0000);
        rd32(8, rv);  check("t3_xori", rv, 64'h8000_00FF);
        rd32(9, rv);  check("t3_nor", rv, 64'hFFFF_FFFF);
        rd32(10, rv); check("t3_andi", rv, 64'h0000_1234);
        rd32(11, rv); check("t3_xor", rv, 64'h7FFF_FFFF);
        rd32(12, rv); check("t3_slt_pos", rv, 64'd0);
        rd32(13, rv); check("t3_and", rv, 64'h8000_00FF);
        rd32(14, rv); check("t3_addi_wrap", rv, 64'h7FFF_FFFF);
        rd32(15, rv); check("t3_addi_sext", rv, 64'hFFFF_8000);
        check("t3_except", 64'(except), 64'd0);
        check("t3_pc", 64'(pc), 64'd44);
        check("t3_retired", 64'(retired), 64'd11);

        // Test 4: write to r0 discarded, then an illegal funct halts.
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 0, 16'h0007);
        prog[1] = enc_r(1, 2, 0, 6'h18);
        do_reset();
        tick(4);
        rd32(0, rv); check("t4_r0", rv, 64'd0);
        check("t4_except", 64'(except), 64'd1);
        check("t4_halted", 64'(halted), 64'd1);
        check("t4_req", 64'(imem_req), 64'd0);
        check("t4_pc", 64'(pc), 64'd4);
        check("t4_retired", 64'(retired), 64'd1);
        tick(5);
        check("t4_frozen_pc", 64'(pc), 64'd4);
        check("t4_frozen_retired", 64'(retired), 64'd1);
        check("t4_frozen_halted", 64'(halted), 64'd1);

        // Test 5a: reset out of HALT.
        valid_en = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_halt_except", 64'(except), 64'd0);
        check("t5_halt_halted", 64'(halted), 64'd0);
        check("t5_halt_pc", 64'(pc), 64'd0);
        check("t5_halt_req", 64'(imem_req), 64'd1);

        // Test 5b: reset mid-fetch with a coincident imem_valid.
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'h0005);
        prog[1] = enc_i(6'h08, 0, 2, 16'h0055);
        valid_en = 1'b1;
        tick(2);
        rd32(1, rv); check("t5_pre_r1", rv, 64'd5);
        valid_en = 1'b0;
        tick(1);
        check("t5_stall_pc", 64'(pc), 64'd4);
        check("t5_stall_req", 64'(imem_req), 64'd1);
        reset = 1'b1;
        valid_en = 1'b1;
        tick(1);
        reset = 1'b0;
        valid_en = 1'b0;
        check("t5_rst_req", 64'(imem_req), 64'd1);
        check("t5_rst_pc", 64'(pc), 64'd0);
        check("t5_rst_retired", 64'(retired), 64'd0);
        rd32(1, rv); check("t5_rst_r1", rv, 64'd0);
        tick(2);
        check("t5_idle_pc", 64'(pc), 64'd0);
        check("t5_idle_retired", 64'(retired), 64'd0);
        check("t5_idle_req", 64'(imem_req), 64'd1);
        rd32(2, rv); check("t5_idle_r2", rv, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
